byte_unstriping: RTL and testbench

BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

---
 rtl/byte_unstriping.sv | 106 ++++++++++
 tb/tb_byte_unstriping.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_unstriping.sv
// ============================================================================
// Module   : byte_unstriping
// Function : Reassembles bytes from 4 serial lanes (two nibble beats each) into
//            a FIFO_DEPTH-entry output buffer. Optional BYTE_UNSTRIPING_PARITY_EN
//            adds a byteParity output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_unstriping #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       byteUnstripingCLK,
  input  logic       byteUnstripingRST_L,
  input  logic       lane0,
  input  logic       lane1,
  input  logic       lane2,
  input  logic       lane3,
  input  logic       laneVLD,
  input  logic       laneSYNC,
  input  logic       outREADY,
  output logic [7:0] byteOUT,
  output logic       byteVLD,
  output logic [3:0] fifoCount,
`ifdef BYTE_UNSTRIPING_PARITY_EN
  output logic       byteParity,
`endif
  output logic       overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
  localparam logic [3:0]       c_full    = 4'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    PHASE_LO = 1'b0,
    PHASE_HI = 1'b1
  } state_t;

  state_t           r_state;
  logic [3:0]       r_lo_nibble;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [3:0]       r_count;
  logic             r_overflow;
  logic [7:0]       r_mem [FIFO_DEPTH];

  logic [3:0] w_beat;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_wr_en;

  assign w_beat  = {lane3, lane2, lane1, lane0};
  // A SYNC beat always starts a new byte, so it can never complete one.
  assign w_push  = laneVLD && !laneSYNC && (r_state == PHASE_HI);
  assign w_pop   = (r_count != 4'd0) && outREADY;
  assign w_full  = (r_count == c_full);
  // A pop in the same edge frees the slot, so a full buffer still accepts.
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge byteUnstripingCLK or negedge byteUnstripingRST_L) begin
    if (!byteUnstripingRST_L) begin
      r_state     <= PHASE_LO;
      r_lo_nibble <= 4'd0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 4'd0;
      r_overflow  <= 1'b0;
    end else begin
      if (laneVLD) begin
        if (laneSYNC || (r_state == PHASE_LO)) begin
          r_lo_nibble <= w_beat;
          r_state     <= PHASE_HI;
        end else begin
          r_state     <= PHASE_LO;
        end
      end
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr_en) r_overflow <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge byteUnstripingCLK) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {w_beat, r_lo_nibble};
  end

  assign byteVLD   = (r_count != 4'd0);
  assign byteOUT   = byteVLD ? r_mem[r_rd_ptr] : 8'h00;
  assign fifoCount = r_count;
  assign overflow  = r_overflow;

`ifdef BYTE_UNSTRIPING_PARITY_EN
  assign byteParity = ^byteOUT;
`endif

endmodule

`default_nettype wire

// File: tb/tb_byte_unstriping.sv
// ============================================================================
// Module   : tb_byte_unstriping
// Function : Self-checking bench for byte_unstriping (vector table + queue model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_unstriping;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       lane0, lane1, lane2, lane3;
  logic       laneVLD, laneSYNC, outREADY;
  logic [7:0] byteOUT;
  logic       byteVLD;
  logic [3:0] fifoCount;
  logic       overflow;
`ifdef BYTE_UNSTRIPING_PARITY_EN
  logic       byteParity;
`endif

  byte_unstriping #(.FIFO_DEPTH(DEPTH)) dut (
    .byteUnstripingCLK  (clk),
    .byteUnstripingRST_L(rst_n),
    .lane0              (lane0),
    .lane1              (lane1),
    .lane2              (lane2),
    .lane3              (lane3),
    .laneVLD            (laneVLD),
    .laneSYNC           (laneSYNC),
    .outREADY           (outREADY),
    .byteOUT            (byteOUT),
    .byteVLD            (byteVLD),
    .fifoCount          (fifoCount),
`ifdef BYTE_UNSTRIPING_PARITY_EN
    .byteParity         (byteParity),
`endif
    .overflow           (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic       m_hi;
  logic [3:0] m_lo;
  logic       m_ovf;
  logic [7:0] sb[$];

  typedef struct {
    logic [3:0] ln;
    logic       vld;
    logic       sync;
    logic       rdy;
    logic [7:0] exp_out;
    logic       exp_vld;
  } vec_t;

  vec_t tbl[13];

  function automatic void check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_hi  = 1'b0;
    m_lo  = 4'd0;
    m_ovf = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_edge(input logic [3:0] ln, input logic v, input logic s,
                                     input logic r);
    logic       push;
    logic [7:0] b;
    push = v && m_hi && !s;
    b    = {ln, m_lo};
    if (v) begin
      if (s || !m_hi) begin
        m_lo = ln;
        m_hi = 1'b1;
      end else begin
        m_hi = 1'b0;
      end
    end
    if (r && sb.size() != 0) void'(sb.pop_front());
    if (push) begin
      if (sb.size() < DEPTH) sb.push_back(b);
      else m_ovf = 1'b1;
    end
  endfunction

  function automatic void compare_model();
    logic [7:0] head;
    head = (sb.size() != 0) ? sb[0] : 8'h00;
    check("byteOUT", int'(byteOUT), int'(head));
    check("byteVLD", int'(byteVLD), int'(sb.size() != 0));
    check("fifoCount", int'(fifoCount), sb.size());
    check("overflow", int'(overflow), int'(m_ovf));
`ifdef BYTE_UNSTRIPING_PARITY_EN
    check("byteParity", int'(byteParity), int'(^head));
`endif
  endfunction

  task automatic step(input logic [3:0] ln, input logic v, input logic s, input logic r);
    {lane3, lane2, lane1, lane0} = ln;
    laneVLD  = v;
    laneSYNC = s;
    outREADY = r;
    @(posedge clk);
    model_edge(ln, v, s, r);
    #1;
    compare_model();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r_lo, input logic r_hi);
    step(b[3:0], 1'b1, 1'b0, r_lo);
    step(b[7:4], 1'b1, 1'b0, r_hi);
  endtask

  task automatic do_reset();
    laneVLD  = 1'b0;
    laneSYNC = 1'b0;
    outREADY = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_byteOUT", int'(byteOUT), 0);
    check("rst_byteVLD", int'(byteVLD), 0);
    check("rst_fifoCount", int'(fifoCount), 0);
    check("rst_overflow", int'(overflow), 0);
`ifdef BYTE_UNSTRIPING_PARITY_EN
    check("rst_byteParity", int'(byteParity), 0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_drain[4];

  initial begin
    // Basic assembly, idle gaps (with ignored SYNC), and realignment
    tbl[0]  = '{4'h5, 1, 0, 1, 8'h00, 0};
    tbl[1]  = '{4'hA, 1, 0, 1, 8'hA5, 1};
    tbl[2]  = '{4'h0, 0, 0, 1, 8'h00, 0};
    tbl[3]  = '{4'h3, 1, 0, 1, 8'h00, 0};
    tbl[4]  = '{4'h0, 0, 0, 1, 8'h00, 0};
    tbl[5]  = '{4'h0, 0, 1, 1, 8'h00, 0};
    tbl[6]  = '{4'hC, 1, 0, 1, 8'hC3, 1};
    tbl[7]  = '{4'h0, 0, 0, 1, 8'h00, 0};
    tbl[8]  = '{4'h1, 1, 0, 1, 8'h00, 0};
    tbl[9]  = '{4'h2, 1, 1, 1, 8'h00, 0};
    tbl[10] = '{4'h7, 1, 0, 1, 8'h72, 1};
    tbl[11] = '{4'h0, 0, 0, 1, 8'h00, 0};
    tbl[12] = '{4'h0, 0, 0, 0, 8'h00, 0};

    rst_n = 1'b0;
    {lane3, lane2, lane1, lane0} = 4'h0;
    laneVLD = 1'b0; laneSYNC = 1'b0; outREADY = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("init_byteVLD", int'(byteVLD), 0);
    check("init_fifoCount", int'(fifoCount), 0);
    check("init_overflow", int'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ln, tbl[i].vld, tbl[i].sync, tbl[i].rdy);
      check($sformatf("tbl%0d_out", i), int'(byteOUT), int'(tbl[i].exp_out));
      check($sformatf("tbl%0d_vld", i), int'(byteVLD), int'(tbl[i].exp_vld));
    end

    // Overflow: five bytes into a four-entry buffer with no consumer
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0, 1'b0);
    check("ovf_count", int'(fifoCount), 4);
    check("ovf_flag", int'(overflow), 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain", int'(byteOUT), i);
      step(4'h0, 1'b0, 1'b0, 1'b1);
    end
    check("ovf_empty", int'(byteVLD), 0);
    check("ovf_sticky", int'(overflow), 1);

    // Full buffer with simultaneous push and pop
    do_reset();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    check("pp_count", int'(fifoCount), 4);
    check("pp_overflow", int'(overflow), 0);
    exp_drain = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      check("pp_drain", int'(byteOUT), int'(exp_drain[i]));
      step(4'h0, 1'b0, 1'b0, 1'b1);
    end
    check("pp_empty", int'(byteVLD), 0);

    // Reset between low and high beats with two bytes buffered
    send_byte(8'hAB, 1'b0, 1'b0);
    send_byte(8'hCD, 1'b0, 1'b0);
    step(4'h9, 1'b1, 1'b0, 1'b0);
    check("mid_count", int'(fifoCount), 2);
    do_reset();
    send_byte(8'h0F, 1'b1, 1'b1);
    check("post_rst_out", int'(byteOUT), 8'h0F);
    check("post_rst_vld", int'(byteVLD), 1);
    step(4'h0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++)
      step(4'($urandom_range(15)), 1'($urandom_range(1)),
           ($urandom_range(7) == 0), ($urandom_range(3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
